// File: rtl/user_pulser_sequencer_if.sv
// Descriptor push channel between the register/OBI front-end and the pulser sequencer.
// The front-end is the master; the sequencer is the slave.
interface user_pulser_sequencer_if;
    logic        desc_valid_i;
    logic        desc_ready_o;
    logic [7:0]  desc_f1_cnt_i;
    logic [7:0]  desc_f2_cnt_i;
    logic [7:0]  desc_stop_cnt_i;
    logic [15:0] desc_f1_end_i;
    logic [15:0] desc_f1_switch_i;
    logic [15:0] desc_f2_end_i;
    logic [15:0] desc_f2_switch_i;

    modport master (
        output desc_valid_i, desc_f1_cnt_i, desc_f2_cnt_i, desc_stop_cnt_i,
               desc_f1_end_i, desc_f1_switch_i, desc_f2_end_i, desc_f2_switch_i,
        input  desc_ready_o
    );

    modport slave (
        input  desc_valid_i, desc_f1_cnt_i, desc_f2_cnt_i, desc_stop_cnt_i,
               desc_f1_end_i, desc_f1_switch_i, desc_f2_end_i, desc_f2_switch_i,
        output desc_ready_o
    );
endinterface

// File: rtl/user_pulser_sequencer.sv
// Descriptor FIFO plus launch/track/gap FSM that drives one user_pulser instance.
// Configuration outputs only change on a FIFO pop, so they stay stable for a whole train.
module user_pulser_sequencer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    user_pulser_sequencer_if.slave       desc,
    input  logic                         enable_i,
    input  logic [15:0]                  gap_i,
    input  logic                         abort_i,
    input  logic                         flush_i,
    input  logic                         err_clr_i,
    output logic                         pls_start_o,
    output logic                         pls_stop_o,
    output logic [7:0]                   pls_f1_cnt_o,
    output logic [7:0]                   pls_f2_cnt_o,
    output logic [7:0]                   pls_stop_cnt_o,
    output logic [15:0]                  pls_f1_end_o,
    output logic [15:0]                  pls_f1_switch_o,
    output logic [15:0]                  pls_f2_end_o,
    output logic [15:0]                  pls_f2_switch_o,
    input  logic [2:0]                   pls_state_i,
    output logic                         busy_o,
    output logic [$clog2(DEPTH+1)-1:0]   level_o,
    output logic                         done_o,
    output logic [15:0]                  done_cnt_o,
    output logic                         err_o
);

    localparam int unsigned LW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned DW = 3 * 8 + 4 * 16;
    localparam logic [2:0]  PLS_IDLE = 3'd0;
    localparam logic [2:0]  PLS_DONE = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_GAP,
        S_ABORT
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   mem [DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]   level_q;
    logic [15:0]     gap_q;
    logic [15:0]     done_cnt_q;
    logic            err_q;
    logic            push, pop, done_evt, lost_evt, gap_load, gap_dec;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign desc.desc_ready_o = (level_q < LW'(DEPTH)) && !flush_i;
    assign push              = desc.desc_valid_i && desc.desc_ready_o;

    // Next-state and strobe decode; abort outranks DONE and lost-train detection.
    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        done_evt = 1'b0;
        lost_evt = 1'b0;
        gap_load = 1'b0;
        gap_dec  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (enable_i && (level_q != '0) && !abort_i && !flush_i) begin
                    pop     = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: state_d = abort_i ? S_ABORT : S_WAIT;
            S_WAIT: begin
                if (abort_i) begin
                    state_d = S_ABORT;
                end else if (pls_state_i == PLS_DONE) begin
                    done_evt = 1'b1;
                    if (gap_i != 16'd0) begin
                        gap_load = 1'b1;
                        state_d  = S_GAP;
                    end else begin
                        state_d  = S_IDLE;
                    end
                end else if (pls_state_i == PLS_IDLE) begin
                    lost_evt = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            S_GAP: begin
                if (abort_i) begin
                    state_d = S_ABORT;
                end else if (gap_q == 16'd0) begin
                    state_d = S_IDLE;
                end else begin
                    gap_dec = 1'b1;
                end
            end
            S_ABORT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FIFO bookkeeping; flush clears occupancy and wins over push/pop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            unique case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr_q] <= {desc.desc_f1_cnt_i, desc.desc_f2_cnt_i, desc.desc_stop_cnt_i,
                              desc.desc_f1_end_i, desc.desc_f1_switch_i,
                              desc.desc_f2_end_i, desc.desc_f2_switch_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            {pls_f1_cnt_o, pls_f2_cnt_o, pls_stop_cnt_o, pls_f1_end_o,
             pls_f1_switch_o, pls_f2_end_o, pls_f2_switch_o} <= '0;
        end else if (pop) begin
            {pls_f1_cnt_o, pls_f2_cnt_o, pls_stop_cnt_o, pls_f1_end_o,
             pls_f1_switch_o, pls_f2_end_o, pls_f2_switch_o} <= mem[rd_ptr_q];
        end
    end

    // Gap countdown, completion counter and sticky error (set beats clear).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gap_q      <= '0;
            done_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            if (gap_load)     gap_q <= gap_i - 16'd1;
            else if (gap_dec) gap_q <= gap_q - 16'd1;
            if (done_evt)     done_cnt_q <= done_cnt_q + 16'd1;
            if (lost_evt)     err_q <= 1'b1;
            else if (err_clr_i) err_q <= 1'b0;
        end
    end

    assign pls_start_o = (state_q == S_START);
    assign pls_stop_o  = (state_q == S_ABORT);
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = done_evt;
    assign level_o     = level_q;
    assign done_cnt_o  = done_cnt_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_user_pulser_sequencer.sv
// Bench for user_pulser_sequencer: a behavioural pulser drives pls_state, a queue-based model
// predicts every output each cycle, and directed scenarios pin hand-computed timings.
module tb_user_pulser_sequencer;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LW    = $clog2(DEPTH + 1);
    localparam int M_IDLE = 0, M_LAUNCH = 1, M_RUN = 2, M_COOL = 3, M_KILL = 4;

    typedef struct packed {
        logic [7:0]  f1c;
        logic [7:0]  f2c;
        logic [7:0]  sc;
        logic [15:0] f1e;
        logic [15:0] f1s;
        logic [15:0] f2e;
        logic [15:0] f2s;
    } desc_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        enable, abort, flush, err_clr, lose;
    logic [15:0] gap;
    logic        pls_start, pls_stop, busy, done, err;
    logic [7:0]  pls_f1_cnt, pls_f2_cnt, pls_stop_cnt;
    logic [15:0] pls_f1_end, pls_f1_switch, pls_f2_end, pls_f2_switch, done_cnt;
    logic [2:0]  pls_state, pl_state;
    logic [LW-1:0] level;
    int          pl_left;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    user_pulser_sequencer_if dif ();

    user_pulser_sequencer #(.DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_ni(rst_n), .desc(dif),
        .enable_i(enable), .gap_i(gap), .abort_i(abort), .flush_i(flush), .err_clr_i(err_clr),
        .pls_start_o(pls_start), .pls_stop_o(pls_stop),
        .pls_f1_cnt_o(pls_f1_cnt), .pls_f2_cnt_o(pls_f2_cnt), .pls_stop_cnt_o(pls_stop_cnt),
        .pls_f1_end_o(pls_f1_end), .pls_f1_switch_o(pls_f1_switch),
        .pls_f2_end_o(pls_f2_end), .pls_f2_switch_o(pls_f2_switch),
        .pls_state_i(pls_state), .busy_o(busy), .level_o(level), .done_o(done),
        .done_cnt_o(done_cnt), .err_o(err)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in pulser: RUN_F1 for f1_cnt+1 cycles, one DONE cycle, then IDLE; stop kills it.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pl_state <= 3'd0;
            pl_left  <= 0;
        end else if (pls_stop) begin
            pl_state <= 3'd0;
        end else if (pls_start) begin
            pl_state <= 3'd1;
            pl_left  <= int'(pls_f1_cnt);
        end else if (pl_state == 3'd1) begin
            if (pl_left == 0) pl_state <= 3'd4;
            else              pl_left  <= pl_left - 1;
        end else if (pl_state == 3'd4) begin
            pl_state <= 3'd0;
        end
    end
    assign pls_state = lose ? 3'd0 : pl_state;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle reference model: descriptor queue, current config, and an activity phase.
    desc_t q[$];
    desc_t cur, in_d;
    logic [87:0] cfg;
    int   mode = M_IDLE;
    int   resume_at = 0;
    logic [15:0] m_dcnt = '0;
    logic m_err = 1'b0;
    logic e_ready, e_done, acc, lost, launch;

    initial begin : compare
        forever begin
            @(negedge clk);
            cfg = {pls_f1_cnt, pls_f2_cnt, pls_stop_cnt, pls_f1_end, pls_f1_switch,
                   pls_f2_end, pls_f2_switch};
            if (!rst_n) begin
                q.delete();
                cur = '0; mode = M_IDLE; m_dcnt = '0; m_err = 1'b0;
            end
            e_ready = (q.size() < int'(DEPTH)) && !flush;
            e_done  = rst_n && (mode == M_RUN) && !abort && (pls_state == 3'd4);
            check("start", pls_start, mode == M_LAUNCH);
            check("stop",  pls_stop,  mode == M_KILL);
            check("busy",  busy,      mode != M_IDLE);
            check("done",  done,      e_done);
            check("level", level,     q.size());
            check("ready", dif.desc_ready_o, e_ready);
            check("cfg",   cfg,       cur);
            check("dcnt",  done_cnt,  m_dcnt);
            check("err",   err,       m_err);
            if (rst_n) begin
                in_d = {dif.desc_f1_cnt_i, dif.desc_f2_cnt_i, dif.desc_stop_cnt_i,
                        dif.desc_f1_end_i, dif.desc_f1_switch_i, dif.desc_f2_end_i,
                        dif.desc_f2_switch_i};
                acc    = dif.desc_valid_i && e_ready;
                lost   = (mode == M_RUN) && !abort && (pls_state == 3'd0);
                launch = (mode == M_IDLE) && enable && (q.size() > 0) && !abort && !flush;
                case (mode)
                    M_IDLE:   if (launch) begin cur = q.pop_front(); mode = M_LAUNCH; end
                    M_LAUNCH: mode = abort ? M_KILL : M_RUN;
                    M_RUN: begin
                        if (abort) mode = M_KILL;
                        else if (e_done) begin
                            m_dcnt = m_dcnt + 16'd1;
                            if (gap != 0) begin
                                resume_at = cyc + int'(gap) + 1;
                                mode = M_COOL;
                            end else mode = M_IDLE;
                        end else if (lost) mode = M_IDLE;
                    end
                    M_COOL: if (abort) mode = M_KILL; else if (cyc + 1 >= resume_at) mode = M_IDLE;
                    default: mode = M_IDLE;
                endcase
                if (lost) m_err = 1'b1;
                else if (err_clr) m_err = 1'b0;
                if (flush) q.delete();
                else if (acc) q.push_back(in_d);
            end
        end
    end

    function automatic desc_t mk(input logic [7:0] f1c, input logic [15:0] f1e,
                                 input logic [15:0] f1s);
        desc_t d;
        d = '0;
        d.f1c = f1c; d.f1e = f1e; d.f1s = f1s;
        if (f1e != 0) begin
            d.f2c = 8'h05; d.sc = 8'h02; d.f2e = f1e + 16'h0100; d.f2s = ~f1e;
        end
        return d;
    endfunction

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic push_desc(input desc_t d, output int at, output logic rdy);
        dif.desc_valid_i = 1'b1;
        {dif.desc_f1_cnt_i, dif.desc_f2_cnt_i, dif.desc_stop_cnt_i, dif.desc_f1_end_i,
         dif.desc_f1_switch_i, dif.desc_f2_end_i, dif.desc_f2_switch_i} = d;
        @(negedge clk);
        rdy = dif.desc_ready_o;
        at  = rdy ? cyc : -1;
        step(1);
        dif.desc_valid_i = 1'b0;
    endtask

    // sel: 0 start, 1 done, 2 stop, 3 not busy. Returns at the next cycle's drive point.
    task automatic wait_ev(input int sel, input int max, output int at);
        at = -1;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if ((sel == 0 && pls_start) || (sel == 1 && done) ||
                (sel == 2 && pls_stop) || (sel == 3 && !busy)) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            checks++; failures++;
            $display("FAIL wait_%0d: event not seen within %0d cycles", sel, max);
        end
        step(1);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int n, s, d, i0, st, ed;
        logic r;
        enable = 0; gap = '0; abort = 0; flush = 0; err_clr = 0; lose = 0;
        dif.desc_valid_i = 0;
        {dif.desc_f1_cnt_i, dif.desc_f2_cnt_i, dif.desc_stop_cnt_i, dif.desc_f1_end_i,
         dif.desc_f1_switch_i, dif.desc_f2_end_i, dif.desc_f2_switch_i} = '0;
        ed = 0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        step(1);

        // Single zero train: start N+2, done N+4, idle again N+5.
        enable = 1;
        push_desc(mk(8'd0, 16'd0, 16'd0), n, r);
        wait_ev(0, 10, s);  check("zero_start_lat", s - n, 2);
        wait_ev(1, 10, d);  check("zero_done_lat", d - n, 4);
        wait_ev(3, 10, i0); check("zero_idle_lat", i0 - n, 5);
        ed = ed + 1;
        check("zero_dcnt", done_cnt, ed);

        // Back-to-back trains with a 5-cycle gap.
        gap = 16'd5;
        repeat (3) push_desc(mk(8'd2, 16'd4, 16'd2), n, r);
        wait_ev(1, 40, d);
        repeat (2) begin
            wait_ev(3, 20, i0); check("gap_idle", i0 - d, 6);
            wait_ev(0, 10, s);  check("gap_restart", s - d, 7);
            check("gap_cfg", pls_f1_end, 16'd4);
            wait_ev(1, 40, d);
        end
        ed = ed + 3;
        step(8);
        check("b2b_dcnt", done_cnt, ed);

        // Fill the FIFO with launching disabled, then drain in order.
        gap = 16'd0; enable = 0;
        for (int k = 0; k < 5; k++) begin
            push_desc(mk(8'd0, 16'(100 + k), 16'd1), n, r);
            check(k < 4 ? "fill_ready" : "full_ready", r, k < 4);
        end
        @(negedge clk);
        check("full_level", level, DEPTH);
        check("full_ready_idle", dif.desc_ready_o, 0);
        step(1);
        enable = 1;
        for (int k = 0; k < 4; k++) begin
            wait_ev(0, 12, s);
            check("drain_order", pls_f1_end, 16'(100 + k));
        end
        wait_ev(1, 10, d);
        ed = ed + 4;
        step(2);
        @(negedge clk);
        check("drain_level", level, 0);
        check("drain_dcnt", done_cnt, ed);
        step(1);

        // Abort while the pulser is in RUN_F1; the next descriptor launches after the stop.
        enable = 0;
        push_desc(mk(8'd10, 16'd200, 16'd3), n, r);
        push_desc(mk(8'd10, 16'd201, 16'd3), n, r);
        enable = 1;
        wait_ev(0, 10, s);
        step(1);
        abort = 1;
        @(negedge clk);
        step(1);
        abort = 0;
        wait_ev(2, 5, st);  check("abort_stop_lat", st - s, 3);
        @(negedge clk);     check("abort_stop_once", pls_stop, 0);
        step(1);
        wait_ev(0, 10, s);  check("abort_next_start", s - st, 2);
        check("abort_next_cfg", pls_f1_end, 16'd201);
        check("abort_dcnt", done_cnt, ed);
        wait_ev(1, 30, d);
        ed = ed + 1;

        // Flush with a same-cycle push while one train runs and two are queued.
        for (int k = 0; k < 3; k++) push_desc(mk(8'd8, 16'(300 + k), 16'd4), n, r);
        step(2);
        flush = 1;
        dif.desc_valid_i = 1;
        dif.desc_f1_end_i = 16'd399;
        @(negedge clk);
        check("flush_ready", dif.desc_ready_o, 0);
        check("flush_level_before", level, 2);
        step(1);
        flush = 0; dif.desc_valid_i = 0;
        @(negedge clk);
        check("flush_level_after", level, 0);
        step(1);
        wait_ev(1, 30, d);
        check("flush_run_cfg", pls_f1_end, 16'd300);
        ed = ed + 1;
        step(6);
        @(negedge clk);
        check("flush_idle", busy, 0);
        check("flush_dcnt", done_cnt, ed);
        step(1);

        // Lost train: sticky error, clear, then clear coincident with a new error.
        push_desc(mk(8'd6, 16'd400, 16'd5), n, r);
        wait_ev(0, 10, s);
        step(1);
        lose = 1;
        step(1);
        lose = 0;
        @(negedge clk);
        check("lost_err", err, 1);
        check("lost_idle", busy, 0);
        step(4);
        @(negedge clk);
        check("lost_sticky", err, 1);
        check("lost_dcnt", done_cnt, ed);
        step(1);
        err_clr = 1;
        step(1);
        err_clr = 0;
        @(negedge clk);
        check("err_cleared", err, 0);
        step(1);
        push_desc(mk(8'd6, 16'd401, 16'd5), n, r);
        wait_ev(0, 10, s);
        step(1);
        lose = 1; err_clr = 1;
        step(1);
        lose = 0; err_clr = 0;
        @(negedge clk);
        check("err_set_wins", err, 1);
        step(10);

        // Reset in the middle of a train.
        push_desc(mk(8'd10, 16'd500, 16'd6), n, r);
        wait_ev(0, 10, s);
        step(1);
        rst_n = 0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_dcnt", done_cnt, 0);
        check("rst_cfg", pls_f1_end, 0);
        check("rst_err", err, 0);
        step(2);
        rst_n = 1;
        step(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
